// File: rtl/bch_pkg.sv
// Shared constants for the shortened BCH(26,16) encoder/decoder path.
//   BCH_N / BCH_K / BCH_P : code length, data length, parity length
//   BCH_GEN               : generator g(x) = x^10+x^9+x^8+x^6+x^5+x^3+1,
//                           stored without its implicit x^10 term
//   bch_state_e           : encoder FSM states
//   bch_lfsr_step         : one MSB-first division step of the parity LFSR
package bch_pkg;

    localparam int unsigned BCH_N = 26;
    localparam int unsigned BCH_K = 16;
    localparam int unsigned BCH_P = 10;

    localparam logic [BCH_P-1:0] BCH_GEN = 10'h369;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bch_state_e;

    // Feedback is the incoming data bit folded with the outgoing LFSR MSB;
    // when set, the generator is subtracted (XORed) after the shift.
    function automatic logic [BCH_P-1:0] bch_lfsr_step(
        input logic [BCH_P-1:0] r,
        input logic             data_bit
    );
        logic fb;
        fb = data_bit ^ r[BCH_P-1];
        return {r[BCH_P-2:0], 1'b0} ^ (fb ? BCH_GEN : '0);
    endfunction

endpackage

// File: rtl/bch_26_enc_lfsr.sv
// Bit-serial parity generator for one 16-bit half of the data word.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous reset, active-low
//   clr      : loads data_in into the internal shift register and zeroes the LFSR
//   shift_en : feeds the next data bit (MSB first) into the LFSR
//   data_in  : 16-bit data half, sampled when clr is high
//   parity   : current LFSR contents; the code parity after 16 shifts
module bch_26_enc_lfsr
    import bch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [BCH_K-1:0] data_in,
    output logic [BCH_P-1:0] parity
);

    logic [BCH_K-1:0] data_sr;
    logic [BCH_P-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_sr <= '0;
            lfsr    <= '0;
        end else if (clr) begin
            data_sr <= data_in;
            lfsr    <= '0;
        end else if (shift_en) begin
            lfsr    <= bch_lfsr_step(lfsr, data_sr[BCH_K-1]);
            data_sr <= {data_sr[BCH_K-2:0], 1'b0};
        end
    end

    assign parity = lfsr;

endmodule

// File: rtl/bch_32_bits_enc_s.sv
// Serial systematic BCH(26,16) encoder for a 32-bit word split into two
// independent blocks, producing the 52-bit dual-block codeword.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous reset, active-low
//   in_valid  : word_in is valid
//   in_ready  : a word can be accepted (IDLE only, low while rst=0)
//   word_in   : [15:0] -> block 1, [31:16] -> block 2
//   out_valid : code_out holds a complete codeword
//   out_ready : downstream accepts code_out
//   err_mask  : XOR mask applied to code_out (only with BCH_ENC_ERR_INJ_EN)
//   code_out  : {data[31:16], parity2, data[15:0], parity1}; zero unless out_valid
// Optional feature macro: BCH_ENC_ERR_INJ_EN (error-injection mask).
module bch_32_bits_enc_s
    import bch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*BCH_K-1:0]   word_in,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef BCH_ENC_ERR_INJ_EN
    input  logic [2*BCH_N-1:0]   err_mask,
`endif
    output logic [2*BCH_N-1:0]   code_out
);

    bch_state_e          state_q, state_d;
    logic [3:0]          cnt_q;
    logic [2*BCH_K-1:0]  hold_q;
    logic [BCH_P-1:0]    parity1, parity2;
    logic                accept;
    logic                shift_en;
    logic [2*BCH_N-1:0]  codeword;

    assign accept   = in_valid && (state_q == IDLE);
    assign shift_en = (state_q == SHIFT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)        state_d = SHIFT;
            SHIFT:   if (cnt_q == 4'd15)  state_d = DONE;
            DONE:    if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                hold_q <= word_in;
                cnt_q  <= '0;
            end else if (shift_en) begin
                cnt_q  <= cnt_q + 4'd1;
            end
        end
    end

    bch_26_enc_lfsr u_lfsr_blk1 (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .shift_en (shift_en),
        .data_in  (word_in[BCH_K-1:0]),
        .parity   (parity1)
    );

    bch_26_enc_lfsr u_lfsr_blk2 (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .shift_en (shift_en),
        .data_in  (word_in[2*BCH_K-1:BCH_K]),
        .parity   (parity2)
    );

    assign codeword = {hold_q[2*BCH_K-1:BCH_K], parity2, hold_q[BCH_K-1:0], parity1};

    // Outputs derive only from state/hold/LFSR registers (and rst for
    // in_ready), so in_valid and out_ready never reach an output directly.
    assign in_ready  = rst && (state_q == IDLE);
    assign out_valid = (state_q == DONE);

`ifdef BCH_ENC_ERR_INJ_EN
    logic [2*BCH_N-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= err_mask;
        end
    end

    assign code_out = out_valid ? (codeword ^ mask_q) : '0;
`else
    assign code_out = out_valid ? codeword : '0;
`endif

endmodule

// File: tb/tb_bch_32_bits_enc_s.sv
// Directed self-checking bench for bch_32_bits_enc_s.
module tb_bch_32_bits_enc_s;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] word_in;
    logic        out_valid;
    logic        out_ready;
    logic [51:0] code_out;
`ifdef BCH_ENC_ERR_INJ_EN
    logic [51:0] err_mask;
`endif

    int n_checks;
    int n_errors;

    bch_32_bits_enc_s dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .word_in   (word_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BCH_ENC_ERR_INJ_EN
        .err_mask  (err_mask),
`endif
        .code_out  (code_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Long division of a polynomial by the full 11-bit generator 0x769.
    function automatic logic [9:0] poly_mod(input logic [25:0] v_in);
        logic [25:0] v;
        v = v_in;
        for (int i = 25; i >= 10; i--) begin
            if (v[i]) v[i-10 +: 11] = v[i-10 +: 11] ^ 11'h769;
        end
        return v[9:0];
    endfunction

    function automatic logic [51:0] model_cw(input logic [31:0] w);
        logic [15:0] d1, d2;
        d1 = w[15:0];
        d2 = w[31:16];
        return {d2, poly_mod({d2, 10'b0}), d1, poly_mod({d1, 10'b0})};
    endfunction

    // Handshake one word, measure latency, hold out_ready low for bp cycles
    // (pulsing in_valid meanwhile), then release the codeword.
    task automatic encode_word(input string tag, input logic [31:0] w,
                               input int bp, output logic [51:0] cw);
        int lat;
        @(negedge clk);
        check({tag, "_rdy_idle"}, {63'b0, in_ready}, 64'd1);
        word_in  = w;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        word_in  = ~w;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd16);
        check({tag, "_rdy_done"}, {63'b0, in_ready}, 64'd0);
        cw = code_out;
        for (int k = 0; k < bp; k++) begin
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_bp_stable"}, {12'b0, code_out}, {12'b0, cw});
            check({tag, "_bp_valid"}, {63'b0, out_valid}, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, {63'b0, out_valid}, 64'd0);
        check({tag, "_rel_rdy"}, {63'b0, in_ready}, 64'd1);
        check({tag, "_rel_zero"}, {12'b0, code_out}, 64'd0);
    endtask

    // Stand-in for the decoder: data fields must match and each block must
    // be divisible by g(x).
    task automatic round_trip(input string tag, input logic [51:0] cw, input logic [31:0] w);
        check({tag, "_rt_d1"}, {48'b0, cw[25:10]}, {48'b0, w[15:0]});
        check({tag, "_rt_d2"}, {48'b0, cw[51:36]}, {48'b0, w[31:16]});
        check({tag, "_rt_syn1"}, {54'b0, poly_mod(cw[25:0])}, 64'd0);
        check({tag, "_rt_syn2"}, {54'b0, poly_mod(cw[51:26])}, 64'd0);
    endtask

    logic [31:0] rnd_words [3];
    logic [51:0] cw;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        word_in   = '0;
`ifdef BCH_ENC_ERR_INJ_EN
        err_mask  = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_code_out", {12'b0, code_out}, 64'd0);
        rst = 1'b1;

        // Hand-computed vectors.
        encode_word("zero", 32'h0000_0000, 0, cw);
        check("zero_cw", {12'b0, cw}, 64'h0);
        encode_word("gen", 32'h0001_0001, 0, cw);
        check("gen_cw", {12'b0, cw}, {12'b0, 26'h0000769, 26'h0000769});
        encode_word("x11", 32'h0002_0000, 0, cw);
        check("x11_cw", {12'b0, cw}, {12'b0, 26'h00009BB, 26'h0});

        // Arbitrary words with backpressure.
        rnd_words[0] = 32'hDEAD_BEEF;
        rnd_words[1] = 32'h8000_FFFF;
        rnd_words[2] = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            encode_word("rnd", rnd_words[i], 5, cw);
            check("rnd_cw", {12'b0, cw}, {12'b0, model_cw(rnd_words[i])});
            round_trip("rnd", cw, rnd_words[i]);
        end

        // Reset in the middle of SHIFT.
        @(negedge clk);
        word_in  = 32'hCAFE_F00D;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", {63'b0, out_valid}, 64'd0);
        check("mid_rst_code", {12'b0, code_out}, 64'd0);
        check("mid_rst_rdy", {63'b0, in_ready}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_rdy", {63'b0, in_ready}, 64'd1);
        check("post_rst_valid", {63'b0, out_valid}, 64'd0);
        encode_word("post", 32'h0F0F_A5A5, 0, cw);
        check("post_cw", {12'b0, cw}, {12'b0, model_cw(32'h0F0F_A5A5)});

`ifdef BCH_ENC_ERR_INJ_EN
        err_mask = 52'h1;
        encode_word("inj1", 32'h1357_9BDF, 0, cw);
        check("inj1_cw", {12'b0, cw}, {12'b0, model_cw(32'h1357_9BDF) ^ 52'h1});
        check("inj1_detect", {63'b0, (poly_mod(cw[25:0]) != 10'h0)}, 64'd1);
        err_mask = '0;
        encode_word("inj0", 32'h1357_9BDF, 0, cw);
        check("inj0_cw", {12'b0, cw}, {12'b0, model_cw(32'h1357_9BDF)});
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
